// File: rtl/kgp_seq_pkg.sv
// Shared definitions for the KGP-RISC multi-cycle sequencer: state codes,
// default widths and the block-RAM latency bounds.
package kgp_seq_pkg;

  localparam int DEF_PC_W    = 12;
  localparam int DEF_LABEL_W = 26;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Value loaded into the 2-bit latency counter on entry to WAIT/MEM.
  // Out-of-range latencies are clamped so the counter can never overflow.
  function automatic logic [1:0] lat_load(input int lat);
    int l;
    l = lat;
    if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
    if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
    return 2'(l - 1);
  endfunction

endpackage

// File: rtl/kgp_seq_if.sv
// Sequencer <-> core bus: decode/branch inputs, program counter and memory strobes.
// All strobes are single-cycle level pulses with no back-pressure; decode inputs are
// sampled only in the state that needs them, so they may change freely at other times.
interface kgp_seq_if
  import kgp_seq_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int LABEL_W = DEF_LABEL_W
);

  logic               run;
  logic               isBranch;
  logic [LABEL_W-1:0] label;
  logic               is_mem;
  logic               is_halt;
  logic [PC_W-1:0]    pc;
  logic               imem_en;
  logic               ir_load;
  logic               dmem_en;
  logic               reg_we;

  modport master (
    input  run, isBranch, label, is_mem, is_halt,
    output pc, imem_en, ir_load, dmem_en, reg_we
  );

  modport slave (
    output run, isBranch, label, is_mem, is_halt,
    input  pc, imem_en, ir_load, dmem_en, reg_we
  );

endinterface

// File: rtl/kgp_seq_lat_cnt.sv
// 2-bit loadable down-counter timing the block-RAM wait in WAIT and MEM.
// Counts down to zero and then holds; zero tells the FSM the wait is over.
module kgp_seq_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] count,
  output logic       zero
);

  logic [1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != 2'd0) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == 2'd0);

endmodule

// File: rtl/kgp_seq_ctrl.sv
// KGP-RISC multi-cycle sequencer: owns the PC and steps FETCH/WAIT/DECODE/EXEC/MEM/WB.
// Optional retired-instruction counter output instr_cnt when KGP_SEQ_PERF_CNT_EN is defined.
module kgp_seq_ctrl
  import kgp_seq_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int LABEL_W = DEF_LABEL_W,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  kgp_seq_if.master   bus,
  output logic [2:0]  state,
  output logic        halted
`ifdef KGP_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [1:0] LAT_LOAD = lat_load(MEM_LAT);

  state_t          cur;
  state_t          nxt;
  logic [PC_W-1:0] pc_q;
  logic            mem_q;
  logic            imem_en_q;
  logic            ir_load_q;
  logic            dmem_en_q;
  logic            reg_we_q;
  logic            cnt_load;
  logic            cnt_zero;
  logic [1:0]      cnt_val;
  logic            nxt_cnt_zero;
  logic            label_unused;

  // Only the low PC_W bits of the branch target address instruction memory.
  assign label_unused = ^bus.label;

  kgp_seq_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (bus.run) nxt = S_FETCH;
      S_FETCH:  nxt = S_WAIT;
      S_WAIT:   if (cnt_zero) nxt = S_DECODE;
      S_DECODE: nxt = bus.is_halt ? S_HALT : S_EXEC;
      S_EXEC:   nxt = mem_q ? S_MEM : S_WB;
      S_MEM:    if (cnt_zero) nxt = S_WB;
      S_WB:     nxt = bus.run ? S_FETCH : S_IDLE;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  assign cnt_load = ((nxt == S_WAIT) && (cur != S_WAIT)) ||
                    ((nxt == S_MEM)  && (cur != S_MEM));
  // Counter value in the next cycle is zero: that cycle is the last one of the wait.
  assign nxt_cnt_zero = cnt_load ? (LAT_LOAD == 2'd0) : (cnt_val == 2'd1);

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= S_IDLE;
      pc_q      <= '0;
      mem_q     <= 1'b0;
      imem_en_q <= 1'b0;
      ir_load_q <= 1'b0;
      dmem_en_q <= 1'b0;
      reg_we_q  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) mem_q <= bus.is_mem;
      if (cur == S_EXEC) begin
        pc_q <= bus.isBranch ? bus.label[PC_W-1:0] : pc_q + PC_W'(1);
      end
      imem_en_q <= (nxt == S_FETCH);
      ir_load_q <= (nxt == S_WAIT) && nxt_cnt_zero;
      dmem_en_q <= (nxt == S_MEM) && (cur != S_MEM);
      reg_we_q  <= (nxt == S_WB);
      halted    <= (nxt == S_HALT);
    end
  end

`ifdef KGP_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= 32'd0;
    end else if (cur == S_WB) begin
      instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

  assign state       = cur;
  assign bus.pc      = pc_q;
  assign bus.imem_en = imem_en_q;
  assign bus.ir_load = ir_load_q;
  assign bus.dmem_en = dmem_en_q;
  assign bus.reg_we  = reg_we_q;

endmodule

// File: tb/tb_kgp_seq_ctrl.sv
// Bench for kgp_seq_ctrl: per-instruction cycle traces built from the sequencing rules
// are queued as expected output vectors and compared every cycle.
module tb_kgp_seq_ctrl;

  localparam int LAT      = 1;
  localparam int HALT_CYC = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_MEM    = 3'd5;
  localparam logic [2:0] ST_WB     = 3'd6;
  localparam logic [2:0] ST_HALT   = 3'd7;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  kgp_seq_if #(.PC_W(12), .LABEL_W(26)) bus ();
  logic [2:0] dbg_state;
  logic       halted;
`ifdef KGP_SEQ_PERF_CNT_EN
  logic [31:0] instr_cnt;
`endif

  kgp_seq_ctrl #(.PC_W(12), .LABEL_W(26), .MEM_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state     (dbg_state),
    .halted    (halted)
`ifdef KGP_SEQ_PERF_CNT_EN
    ,
    .instr_cnt (instr_cnt)
`endif
  );

  // scoreboard
  logic [19:0] exp_q[$];
  int          n_cmp;
  int          n_err;
  logic [11:0] m_pc;
  logic [31:0] m_cnt;

  function automatic logic [19:0] mk(input logic [2:0] s, input logic [11:0] p,
                                     input logic i, input logic r, input logic d,
                                     input logic w, input logic h);
    return {s, p, i, r, d, w, h};
  endfunction

  function automatic logic [19:0] obs();
    return mk(dbg_state, bus.pc, bus.imem_en, bus.ir_load, bus.dmem_en, bus.reg_we, halted);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
`ifdef KGP_SEQ_PERF_CNT_EN
    check(tag, instr_cnt, m_cnt);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // driver tasks
  task automatic rand_inputs();
    bus.run      = 1'($urandom_range(0, 1));
    bus.isBranch = 1'($urandom_range(0, 1));
    bus.label    = 26'($urandom());
    bus.is_mem   = 1'($urandom_range(0, 1));
    bus.is_halt  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rand_inputs();
    tick();
    check("reset", obs(), mk(ST_IDLE, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    m_pc  = 12'd0;
    m_cnt = 32'd0;
    check_cnt("reset_cnt");
    rst = 1'b0;
  endtask

  // Sit in IDLE for n cycles with run low, raising run in the last one.
  task automatic idle_go(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle", obs(), mk(ST_IDLE, m_pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      rand_inputs();
      bus.run = (i == n - 1);
      tick();
    end
  endtask

  // Starts in the FETCH cycle of one instruction and runs it to completion
  // (or into HALT, or until a reset fired in its first MEM cycle).
  task automatic do_instr(input bit mem, input bit halt, input bit br,
                          input logic [25:0] lbl, input bit run_after, input bit abort);
    logic [11:0] p;
    logic [11:0] np;
    logic [19:0] e;
    logic [2:0]  s;
    bit          aborted;
    p  = m_pc;
    np = br ? lbl[11:0] : p + 12'd1;
    aborted = 1'b0;
    exp_q.push_back(mk(ST_FETCH, p, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < LAT; i++)
      exp_q.push_back(mk(ST_WAIT, p, 1'b0, (i == LAT - 1), 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(ST_DECODE, p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (halt) begin
      for (int i = 0; i < HALT_CYC; i++)
        exp_q.push_back(mk(ST_HALT, p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      exp_q.push_back(mk(ST_EXEC, p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      if (mem)
        for (int i = 0; i < LAT; i++)
          exp_q.push_back(mk(ST_MEM, np, 1'b0, 1'b0, (i == 0), 1'b0, 1'b0));
      exp_q.push_back(mk(ST_WB, np, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = e[19:17];
      check($sformatf("cyc_st%0d_pc%03h", s, p), obs(), e);
      rand_inputs();
      if (s == ST_WB) begin
        bus.run = run_after;
        m_cnt++;
      end
      if (s == ST_HALT) bus.run = ~bus.run;
      if (s == ST_DECODE) begin
        bus.is_mem  = mem;
        bus.is_halt = halt;
      end
      if (s == ST_EXEC) begin
        bus.is_mem   = ~mem;
        bus.isBranch = br;
        bus.label    = lbl;
      end
      if (abort && s == ST_MEM && !aborted) begin
        rst = 1'b1;
        aborted = 1'b1;
        exp_q.delete();
      end
      tick();
    end
    if (aborted) begin
      check("abort", obs(), mk(ST_IDLE, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      rst   = 1'b0;
      m_pc  = 12'd0;
      m_cnt = 32'd0;
    end else if (!halt) begin
      m_pc = np;
    end
    check_cnt("instr_cnt");
  endtask

  // stimulus
  initial begin
    bit          rm;
    bit          rb;
    bit          ra;
    logic [25:0] rl;
    n_cmp = 0;
    n_err = 0;
    m_pc  = 12'd0;
    m_cnt = 32'd0;
    rst   = 1'b1;
    rand_inputs();

    do_reset();
    idle_go(3);
    do_instr(1'b0, 1'b0, 1'b0, 26'd0, 1'b1, 1'b0);
    do_instr(1'b0, 1'b0, 1'b1, 26'd24, 1'b1, 1'b0);
    do_instr(1'b0, 1'b0, 1'b1, 26'h3FFF018, 1'b1, 1'b0);
    do_instr(1'b1, 1'b0, 1'b0, 26'd0, 1'b1, 1'b0);
    do_instr(1'b0, 1'b0, 1'b1, 26'd4095, 1'b1, 1'b0);
    do_instr(1'b0, 1'b0, 1'b0, 26'd0, 1'b0, 1'b0);
    idle_go(2);

    for (int k = 0; k < 40; k++) begin
      rm = 1'($urandom_range(0, 1));
      rb = ($urandom_range(0, 2) == 0);
      rl = 26'($urandom());
      if ($urandom_range(0, 3) == 0) rl[11:0] = 12'hFFF;
      ra = ($urandom_range(0, 4) != 0);
      do_instr(rm, 1'b0, rb, rl, ra, 1'b0);
      if (!ra) idle_go($urandom_range(1, 3));
    end

    do_instr(1'b1, 1'b0, 1'b1, 26'd77, 1'b1, 1'b1);
    idle_go(2);
    do_instr(1'b1, 1'b1, 1'b0, 26'd0, 1'b1, 1'b0);
    do_reset();
    idle_go(1);
    do_instr(1'b0, 1'b0, 1'b0, 26'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog time_limit reached got=running exp=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kgp_seq_ctrl.md
# kgp_seq_ctrl

Multi-cycle sequencer for the KGP-RISC core. It owns the program counter and steps each instruction through fetch, instruction-memory wait, decode, execute, optional data-memory access and write-back. It drives the strobes for the block-RAM instruction/data memories and the register file. It applies branch redirects from the decoder/ALU and parks the core on a halt opcode.

## Interface
- `PC_W`, 12: program-counter width (instruction-memory depth 2^PC_W).
- `LABEL_W`, 26: width of branch target field from the instruction.
- `MEM_LAT`, 1: block-RAM read latency in cycles, legal 1..3.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; permits leaving IDLE and continuing after WB.
- `isBranch`  in  1  branch taken, sampled in EXEC.
- `label`  in  LABEL_W  branch target; bits [PC_W-1:0] used, upper bits ignored.
- `is_mem`  in  1  instruction accesses data memory, sampled in DECODE.
- `is_halt`  in  1  halt opcode, sampled in DECODE.
- `pc`  out  PC_W  current instruction address (registered).
- `imem_en`  out  1  instruction-memory read enable.
- `ir_load`  out  1  latch instruction register.
- `dmem_en`  out  1  data-memory enable.
- `reg_we`  out  1  register-file write enable.
- `state`  out  3  current state code (debug).
- `halted`  out  1  high while in HALT.

## Operation
- States and codes: IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT=7.
- Moore outputs, decoded from the state register only:
  - `imem_en` is high in FETCH.
  - `ir_load` is high in the last WAIT cycle.
  - `dmem_en` is high in the first MEM cycle.
  - `reg_we` is high in WB.
  - `halted` is high in HALT.
- State transitions:
  - IDLE goes to FETCH when `run`=1.
  - FETCH goes to WAIT.
  - WAIT lasts MEM_LAT cycles, then goes to DECODE.
  - DECODE goes to HALT if `is_halt`, else to EXEC. `is_halt` has priority over `is_mem`.
  - EXEC goes to MEM if the latched `is_mem`=1, else to WB.
  - MEM lasts MEM_LAT cycles, then goes to WB.
  - WB goes to FETCH if `run`=1, else to IDLE.
  - HALT is terminal until `rst`.
- PC update happens only on the EXEC→next edge:
  - `pc` <= `isBranch` ? `label[PC_W-1:0]` : `pc`+1.
  - The increment wraps modulo 2^PC_W (4095→0).
- `pc` is held in every other state, including HALT.
- `is_mem` is latched in DECODE. Later changes of the input are ignored.
- `run` is examined only in IDLE and WB. Deasserting it mid-instruction lets that instruction complete.

## Timing
- Reset: `state`=IDLE, `pc`=0. All strobes and `halted` are 0 in the cycle after `rst` is sampled high.
- `rst` mid-operation, in any state including HALT, aborts the instruction. No further strobes are issued and no PC update occurs.
- Non-memory instruction takes 4+MEM_LAT cycles (5 at MEM_LAT=1).
- Memory instruction takes 4+2·MEM_LAT cycles.
- With `run` held high, the next FETCH immediately follows WB, with no bubble.
- New `pc` is visible in the cycle after EXEC, i.e. during MEM/WB. FETCH therefore always uses the updated value.
- Latency counter: a down-counter loaded with MEM_LAT-1 on entry to WAIT/MEM; the state exits when it reaches 0.

## Configuration
- `KGP_SEQ_PERF_CNT_EN` defined: adds output `instr_cnt` (32 bits, reset 0).
  - Increments once per WB cycle and wraps at 2^32.
  - Halted instructions are not counted.
- `KGP_SEQ_PERF_CNT_EN` undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Package `kgp_seq_pkg`: state-code constants (3 bits), default PC_W/LABEL_W, MEM_LAT bounds.
- Sub-module `kgp_seq_lat_cnt`: 2-bit loadable down-counter with `load`, `load_val` and `zero` outputs, shared by WAIT and MEM.

## Test plan
- Reset then `run`=1, MEM_LAT=1, all decode inputs 0 → `imem_en` 1 cycle, `ir_load` next cycle, `reg_we` in 5th cycle; `pc` 0→1; second FETCH in cycle 6.
- `isBranch`=1, `label`=26'd24 during EXEC → `pc`=24 next cycle. `label`=26'h3FFF018 → `pc`=12'h018.
- `is_mem`=1 in DECODE, input dropped to 0 in EXEC → MEM still entered; `dmem_en` exactly 1 cycle; instruction takes 6 cycles.
- `pc`=4095 with no branch → `pc`=0 after EXEC.
- `is_halt`=1 and `is_mem`=1 in DECODE → HALT, `halted`=1, `pc` frozen, no `reg_we`. Toggling `run` has no effect. `rst` → IDLE, `pc`=0.
- `rst` asserted while in MEM → next cycle `state`=0, `pc`=0, all strobes 0. With perf counter compiled in, `instr_cnt`=0.
